// File: rtl/inst_rom_pipe_pkg.sv
// ============================================================================
// Module   : inst_rom_pipe_pkg
// Brief    : Shared constants and helpers for the pipelined instruction ROM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package inst_rom_pipe_pkg;

    localparam logic [31:0] ZeroWord       = 32'h0000_0000;
    localparam logic        ChipEnable     = 1'b1;
    localparam logic        ChipDisable    = 1'b0;
    localparam int          InstMemNumLog2 = 10;
    localparam int          MaxLatency     = 4;

    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

`default_nettype wire

// File: rtl/inst_mem_sp.sv
// ============================================================================
// Module   : inst_mem_sp
// Brief    : Single-port synchronous read-first instruction memory with a
//            registered read output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_mem_sp
    import inst_rom_pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = InstMemNumLog2
) (
    input  logic                  clk,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_idx,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_idx,
    input  logic [DATA_W-1:0]     wr_data,
    output logic [DATA_W-1:0]     rd_data
);

    logic [DATA_W-1:0] r_mem_q [2**DEPTH_LOG2];
    logic [DATA_W-1:0] r_rd_data_q;
    logic [DATA_W-1:0] w_rd_data_d;

    // Read samples the array before this edge's write lands, giving old data
    // on a same-word collision.
    always_comb begin
        w_rd_data_d = r_rd_data_q;
        if (rd_en) begin
            w_rd_data_d = r_mem_q[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem_q[wr_idx] <= wr_data;
        end
        r_rd_data_q <= w_rd_data_d;
    end

    assign rd_data = r_rd_data_q;

endmodule

`default_nettype wire

// File: rtl/inst_rom_pipe.sv
// ============================================================================
// Module   : inst_rom_pipe
// Brief    : Pipelined instruction ROM with valid/ready fetch handshake,
//            flush, error reporting and a program-load write port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_rom_pipe
    import inst_rom_pipe_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = InstMemNumLog2,
    parameter int LATENCY    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_inst,
    output logic              resp_err,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    // Out-of-range LATENCY values are clamped to the supported 1..MaxLatency.
    localparam int c_stages = (LATENCY < 1) ? 1 :
                              ((LATENCY > MaxLatency) ? MaxLatency : LATENCY);
    localparam int c_idx_hi = DEPTH_LOG2 + 1;

    logic                w_advance;
    logic                w_accept;
    logic                w_req_oor;
    logic                w_wr_oor;
    logic                w_req_bad;
    logic                w_wr_ok;
    logic [c_stages-1:0] r_valid_q, w_valid_d;
    logic [c_stages-1:0] r_err_q,   w_err_d;
    logic [DATA_W-1:0]   w_stage_data [c_stages];

    generate
        if (ADDR_W > DEPTH_LOG2 + 2) begin : g_range
            assign w_req_oor = |req_addr[ADDR_W-1:DEPTH_LOG2+2];
            assign w_wr_oor  = |wr_addr[ADDR_W-1:DEPTH_LOG2+2];
        end else begin : g_no_range
            assign w_req_oor = 1'b0;
            assign w_wr_oor  = 1'b0;
        end
    endgenerate

    assign resp_valid = r_valid_q[c_stages-1];
    assign w_advance  = !resp_valid || resp_ready;
    assign req_ready  = rst && (ce == ChipEnable) && !flush && w_advance;
    assign w_accept   = req_valid && req_ready;
    assign w_req_bad  = !is_word_aligned(req_addr[1:0]) || w_req_oor;
    assign w_wr_ok    = wr_en && rst && is_word_aligned(wr_addr[1:0]) && !w_wr_oor;

    inst_mem_sp #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk     (clk),
        .rd_en   (w_advance),
        .rd_idx  (req_addr[c_idx_hi:2]),
        .wr_en   (w_ok_gate(w_wr_ok)),
        .wr_idx  (wr_addr[c_idx_hi:2]),
        .wr_data (wr_data),
        .rd_data (w_stage_data[0])
    );

    function automatic logic w_ok_gate(input logic en);
        return en;
    endfunction

    generate
        for (genvar i = 1; i < c_stages; i++) begin : g_stage
            logic [DATA_W-1:0] r_data_q;
            logic [DATA_W-1:0] w_data_d;

            always_comb begin
                w_data_d = r_data_q;
                if (w_advance) begin
                    w_data_d = w_stage_data[i-1];
                end
            end

            always_ff @(posedge clk) begin
                r_data_q <= w_data_d;
            end

            assign w_stage_data[i] = r_data_q;
        end
    endgenerate

    // Whole pipe moves as one; a stalled output freezes every stage.
    always_comb begin
        w_valid_d = r_valid_q;
        w_err_d   = r_err_q;
        if (flush) begin
            w_valid_d = '0;
            w_err_d   = '0;
        end else if (w_advance) begin
            w_valid_d    = r_valid_q << 1;
            w_valid_d[0] = w_accept;
            w_err_d      = r_err_q << 1;
            w_err_d[0]   = w_accept && w_req_bad;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid_q <= '0;
            r_err_q   <= '0;
        end else begin
            r_valid_q <= w_valid_d;
            r_err_q   <= w_err_d;
        end
    end

    assign resp_err  = resp_valid && r_err_q[c_stages-1];
    assign resp_inst = (resp_valid && !r_err_q[c_stages-1]) ? w_stage_data[c_stages-1]
                                                           : DATA_W'(ZeroWord);

endmodule

`default_nettype wire

// File: tb/tb_inst_rom_pipe.sv
// ============================================================================
// Module   : tb_inst_rom_pipe
// Brief    : Directed self-checking bench for inst_rom_pipe (LATENCY=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_rom_pipe;
    import inst_rom_pipe_pkg::*;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_inst;
    logic        resp_err;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    int errors;
    int checks;

    inst_rom_pipe #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .DEPTH_LOG2 (10),
        .LATENCY    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_inst  (resp_inst),
        .resp_err   (resp_err),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_word(input logic [31:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic rd_one(input logic [31:0] a, output logic [31:0] inst, output logic err);
        inst = 'x;
        err  = 1'bx;
        req_valid = 1'b1; req_addr = a;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (resp_valid) begin
                inst = resp_inst;
                err  = resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; ce = ChipEnable; req_valid = 1'b1; req_addr = 32'h0; resp_ready = 1'b1;
        step();
        step();
        #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        checks++; if (resp_inst !== 32'h0) begin errors++; $display("FAIL reset_resp_inst got=%h exp=0", resp_inst); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got=%b exp=0", resp_err); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
        req_valid = 1'b0;
        rst = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        wr_word(32'h0, 32'h3401_1100);
        wr_word(32'h4, 32'h3402_0020);
        wr_word(32'h8, 32'h3403_ff00);
        resp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 32'h0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_req_ready got=%b exp=1", req_ready); end
        step();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_early_valid got=%b exp=0", resp_valid); end
        req_addr = 32'h4;
        step();
        checks++; if (resp_valid !== 1'b1 || resp_inst !== 32'h3401_1100) begin errors++; $display("FAIL b2b_resp0 got=%b/%h exp=1/34011100", resp_valid, resp_inst); end
        req_addr = 32'h8;
        step();
        req_valid = 1'b0;
        checks++; if (resp_valid !== 1'b1 || resp_inst !== 32'h3402_0020) begin errors++; $display("FAIL b2b_resp1 got=%b/%h exp=1/34020020", resp_valid, resp_inst); end
        step();
        checks++; if (resp_valid !== 1'b1 || resp_inst !== 32'h3403_ff00) begin errors++; $display("FAIL b2b_resp2 got=%b/%h exp=1/3403ff00", resp_valid, resp_inst); end
        step();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got=%b exp=0", resp_valid); end
    endtask

    task automatic test_backpressure();
        resp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 32'h0;
        step();
        req_addr = 32'h4;
        step();
        checks++; if (resp_valid !== 1'b1 || resp_inst !== 32'h3401_1100) begin errors++; $display("FAIL bp_first got=%b/%h exp=1/34011100", resp_valid, resp_inst); end
        req_addr = 32'h8;
        resp_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready got=%b exp=0", req_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (resp_valid !== 1'b1 || resp_inst !== 32'h3401_1100) begin errors++; $display("FAIL bp_hold%0d got=%b/%h exp=1/34011100", i, resp_valid, resp_inst); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready%0d got=%b exp=0", i, req_ready); end
        end
        resp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        checks++; if (resp_valid !== 1'b1 || resp_inst !== 32'h3402_0020) begin errors++; $display("FAIL bp_resp1 got=%b/%h exp=1/34020020", resp_valid, resp_inst); end
        step();
        checks++; if (resp_valid !== 1'b1 || resp_inst !== 32'h3403_ff00) begin errors++; $display("FAIL bp_resp2 got=%b/%h exp=1/3403ff00", resp_valid, resp_inst); end
        step();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got=%b exp=0", resp_valid); end
    endtask

    task automatic test_errors();
        logic [31:0] inst;
        logic        err;
        resp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 32'h2;
        step();
        req_addr = 32'h1000;
        step();
        req_valid = 1'b0;
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_inst !== 32'h0) begin errors++; $display("FAIL err_misaligned got=%b/%b/%h exp=1/1/0", resp_valid, resp_err, resp_inst); end
        step();
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_inst !== 32'h0) begin errors++; $display("FAIL err_range got=%b/%b/%h exp=1/1/0", resp_valid, resp_err, resp_inst); end
        step();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL err_drained got=%b exp=0", resp_valid); end
        wr_word(32'h1000, 32'hdead_beef);
        wr_word(32'h2, 32'hdead_beef);
        rd_one(32'h0, inst, err);
        checks++; if (inst !== 32'h3401_1100 || err !== 1'b0) begin errors++; $display("FAIL err_bad_write_ignored got=%h/%b exp=34011100/0", inst, err); end
    endtask

    task automatic test_chip_enable();
        int seen;
        seen = 0;
        ce = ChipDisable; req_valid = 1'b1; req_addr = 32'h4;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL ce_req_ready got=%b exp=0", req_ready); end
        for (int i = 0; i < 4; i++) begin
            step();
            if (resp_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL ce_no_resp got=%0d exp=0", seen); end
        req_valid = 1'b0; ce = ChipEnable;
    endtask

    task automatic test_flush();
        int seen;
        seen = 0;
        resp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 32'h0;
        step();
        req_addr = 32'h4;
        step();
        flush = 1'b1; req_addr = 32'h8;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_req_ready got=%b exp=0", req_ready); end
        step();
        flush = 1'b0; req_valid = 1'b0;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL flush_valid_cleared got=%b exp=0", resp_valid); end
        for (int i = 0; i < 5; i++) begin
            step();
            if (resp_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_late_resp got=%0d exp=0", seen); end
    endtask

    task automatic test_collision();
        resp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 32'h4;
        wr_en = 1'b1; wr_addr = 32'h4; wr_data = 32'h3404_ffff;
        step();
        wr_en = 1'b0;
        step();
        req_valid = 1'b0;
        checks++; if (resp_valid !== 1'b1 || resp_inst !== 32'h3402_0020) begin errors++; $display("FAIL coll_read_first got=%b/%h exp=1/34020020", resp_valid, resp_inst); end
        step();
        checks++; if (resp_valid !== 1'b1 || resp_inst !== 32'h3404_ffff) begin errors++; $display("FAIL coll_new_data got=%b/%h exp=1/3404ffff", resp_valid, resp_inst); end
        step();
    endtask

    task automatic test_reset_mid();
        logic [31:0] inst;
        logic        err;
        int          seen;
        seen = 0;
        resp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 32'h0;
        step();
        req_addr = 32'h8;
        step();
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rstmid_req_ready got=%b exp=0", req_ready); end
        step();
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL rstmid_cleared got=%b/%b exp=0/0", resp_valid, req_ready); end
        rst = 1'b1; req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (resp_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_no_stale got=%0d exp=0", seen); end
        rd_one(32'h8, inst, err);
        checks++; if (inst !== 32'h3403_ff00 || err !== 1'b0) begin errors++; $display("FAIL rstmid_mem_kept8 got=%h/%b exp=3403ff00/0", inst, err); end
        rd_one(32'h4, inst, err);
        checks++; if (inst !== 32'h3404_ffff || err !== 1'b0) begin errors++; $display("FAIL rstmid_mem_kept4 got=%h/%b exp=3404ffff/0", inst, err); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        errors = 0; checks = 0;
        rst = 1'b0; ce = ChipEnable; flush = 1'b0;
        req_valid = 1'b0; req_addr = 32'h0; resp_ready = 1'b1;
        wr_en = 1'b0; wr_addr = 32'h0; wr_data = 32'h0;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_errors();
        test_chip_enable();
        test_flush();
        test_collision();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
